vga_rx_monitor: RTL and testbench



---
 rtl/vga_rx_monitor.sv | 158 +++++++++++++++
 tb/tb_vga_rx_monitor.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_rx_monitor.sv
// vga_rx_monitor: recovers x/y from hsync/vsync, checks line/frame timing, tracks lock and error count.
// Optional macro FRAME_SUM_EN adds a per-frame sum of active rgb values.
module vga_rx_monitor #(
    parameter int   H_ACTIVE    = 640,
    parameter int   H_FP        = 16,
    parameter int   H_TOTAL     = 800,
    parameter int   V_ACTIVE    = 480,
    parameter int   V_FP        = 10,
    parameter int   V_TOTAL     = 525,
    parameter logic SYNC_ACT    = 1'b1,
    parameter int   LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p_tick,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [11:0] rgb,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        de,
    output logic        locked,
    output logic        frame_start,
    output logic [7:0]  err_cnt,
    output logic [31:0] frame_sum,
    output logic        frame_sum_valid
);
    localparam logic [9:0] HA  = 10'(H_ACTIVE);
    localparam logic [9:0] HS  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HT1 = 10'(H_TOTAL - 1);
    localparam logic [9:0] VA  = 10'(V_ACTIVE);
    localparam logic [9:0] VS  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VT  = 10'(V_TOTAL);
    localparam logic [9:0] VT1 = 10'(V_TOTAL - 1);
    localparam logic [7:0] LF  = 8'(LOCK_FRAMES);

    typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} state_t;

    state_t      r_state;
    logic [7:0]  r_good;
    logic        r_hs_prev;
    logic        r_vs_prev;
    logic [9:0]  r_lp;
    logic [9:0]  r_fc;
    logic        r_h_armed;
    logic        r_v_armed;
    logic        r_dirty;

    logic        w_hs_edge;
    logic        w_vs_edge;
    logic        w_x_wrap;
    logic [9:0]  w_x;
    logic [9:0]  w_y;
    logic        w_de;
    logic        w_line_err;
    logic        w_timeout;
    logic        w_frame_err;
    logic        w_align_err;
    logic        w_err;
    logic        w_unlock;

    assign w_hs_edge   = (hsync == SYNC_ACT) && (r_hs_prev != SYNC_ACT);
    assign w_vs_edge   = (vsync == SYNC_ACT) && (r_vs_prev != SYNC_ACT);
    assign w_x_wrap    = !w_hs_edge && x == HT1;
    assign w_x         = w_hs_edge ? HS : (w_x_wrap ? 10'd0 : x + 10'd1);
    // vsync realignment overrides the row step caused by an x wrap
    assign w_y         = w_vs_edge ? VS : (w_x_wrap ? (y == VT1 ? 10'd0 : y + 10'd1) : y);
    assign w_de        = locked && w_x < HA && w_y < VA;
    assign w_line_err  = w_hs_edge && r_h_armed && r_lp != HT1;
    assign w_timeout   = !w_hs_edge && r_lp == 10'd1022;
    assign w_frame_err = w_vs_edge && r_v_armed && r_fc != VT;
    assign w_align_err = w_vs_edge && w_x != 10'd0;
    assign w_err       = w_line_err || w_timeout || w_frame_err || w_align_err;
    assign w_unlock    = r_state == LOCKED && w_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= UNLOCKED;
            r_good      <= '0;
            r_hs_prev   <= !SYNC_ACT;
            r_vs_prev   <= !SYNC_ACT;
            r_lp        <= '0;
            r_fc        <= '0;
            r_h_armed   <= 1'b0;
            r_v_armed   <= 1'b0;
            r_dirty     <= 1'b0;
            x           <= '0;
            y           <= '0;
            de          <= 1'b0;
            locked      <= 1'b0;
            frame_start <= 1'b0;
            err_cnt     <= '0;
        end else begin
            frame_start <= p_tick && w_vs_edge;
            if (p_tick) begin
                r_hs_prev <= hsync;
                r_vs_prev <= vsync;
                x         <= w_x;
                y         <= w_y;
                de        <= w_de;
                r_lp      <= w_hs_edge ? 10'd0 : (&r_lp ? r_lp : r_lp + 10'd1);
                // a coincident hsync edge belongs to the frame that is starting
                r_fc      <= w_vs_edge ? {9'd0, w_hs_edge} : (w_hs_edge && !(&r_fc) ? r_fc + 10'd1 : r_fc);
                r_h_armed <= !w_unlock && (r_h_armed || w_hs_edge);
                r_v_armed <= r_v_armed || w_vs_edge;
                r_dirty   <= !w_vs_edge && (r_dirty || w_err);
                if ((w_unlock || w_timeout) && err_cnt != 8'hFF)
                    err_cnt <= err_cnt + 8'd1;
                case (r_state)
                    UNLOCKED: if (w_vs_edge) begin
                        r_state <= ACQUIRE;
                        r_good  <= '0;
                    end
                    ACQUIRE: if (w_err) begin
                        r_good <= '0;
                    end else if (w_vs_edge && !r_dirty) begin
                        r_good <= r_good + 8'd1;
                        if (r_good + 8'd1 == LF) begin
                            r_state <= LOCKED;
                            locked  <= 1'b1;
                        end
                    end
                    LOCKED: if (w_err) begin
                        r_state <= UNLOCKED;
                        locked  <= 1'b0;
                    end
                    default: r_state <= UNLOCKED;
                endcase
            end
        end
    end

`ifdef FRAME_SUM_EN
    logic [31:0] r_acc;

    // lock is only gained on a vsync edge, so LOCKED at an edge means the whole last frame was locked
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc           <= '0;
            frame_sum       <= '0;
            frame_sum_valid <= 1'b0;
        end else begin
            frame_sum_valid <= p_tick && w_vs_edge && r_state == LOCKED;
            if (p_tick) begin
                r_acc <= (w_vs_edge || w_unlock) ? 32'd0 : r_acc + (w_de ? {20'd0, rgb} : 32'd0);
                if (w_vs_edge && r_state == LOCKED)
                    frame_sum <= r_acc;
            end
        end
    end
`else
    logic w_unused;

    assign w_unused        = ^rgb;
    assign frame_sum       = '0;
    assign frame_sum_valid = 1'b0;
`endif
endmodule

// File: tb/tb_vga_rx_monitor.sv
// tb_vga_rx_monitor: directed checks of sync recovery, lock FSM, error counting and frame sum
// on a reduced raster (64x24 ticks, 48x16 active) so that many frames fit in a short run.
module tb_vga_rx_monitor;
    localparam int HA = 48, HFP = 4, HT = 64, VA = 16, VFP = 2, VT = 24;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        p_tick = 1'b0;
    logic        hsync = 1'b0;
    logic        vsync = 1'b0;
    logic [11:0] rgb = 12'h000;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        de;
    logic        locked;
    logic        frame_start;
    logic [7:0]  err_cnt;
    logic [31:0] frame_sum;
    logic        frame_sum_valid;

    int          tests = 0, fails = 0;
    int          gx = 0, gy = 0, htot = HT, vtot = VT;
    int          n_tick = 0, n_vs = 0, n_fsv = 0, fsv_vs = 0;
    logic [31:0] fsv_sum = 0;
    bit          hmask = 0;

    always #5 clk = ~clk;

    vga_rx_monitor #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_TOTAL(HT),
        .V_ACTIVE(VA), .V_FP(VFP), .V_TOTAL(VT),
        .SYNC_ACT(1'b1), .LOCK_FRAMES(2)
    ) dut (
        .clk(clk), .reset(reset), .p_tick(p_tick), .hsync(hsync), .vsync(vsync), .rgb(rgb),
        .x(x), .y(y), .de(de), .locked(locked), .frame_start(frame_start), .err_cnt(err_cnt),
        .frame_sum(frame_sum), .frame_sum_valid(frame_sum_valid)
    );

    // One pixel tick from the reference raster; every 4th tick is preceded by an idle clk.
    task automatic tick();
        if (n_tick % 4 == 3) begin
            @(posedge clk);
            #1;
        end
        hsync  = !hmask && gx >= HA + HFP && gx < HA + HFP + 8;
        vsync  = gy >= VA + VFP && gy < VA + VFP + 2;
        rgb    = (gx < HA && gy < VA) ? 12'h3F0 : 12'h000;
        p_tick = 1'b1;
        @(posedge clk);
        #1;
        p_tick = 1'b0;
        n_tick++;
        if (frame_start) n_vs++;
        if (frame_sum_valid) begin
            n_fsv++;
            fsv_sum = frame_sum;
            fsv_vs  = n_vs;
        end
        gx++;
        if (gx >= htot) begin
            gx = 0;
            gy++;
            if (gy >= vtot) gy = 0;
        end
    endtask

    task automatic goto(input int tx, input int ty);
        int n;
        n = 0;
        while (!(gx == tx && gy == ty) && n < 4000) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_lock();
        int n;
        n = 0;
        while (!locked && n < 8000) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (x !== 10'd0) begin fails++; $display("FAIL reset_x: got %0d want 0", x); end
        tests++; if (y !== 10'd0) begin fails++; $display("FAIL reset_y: got %0d want 0", y); end
        tests++; if ({de, locked, frame_start, frame_sum_valid} !== 4'b0) begin
            fails++; $display("FAIL reset_flags: got %b want 0000", {de, locked, frame_start, frame_sum_valid});
        end
        tests++; if (err_cnt !== 8'd0) begin fails++; $display("FAIL reset_err: got %0d want 0", err_cnt); end
        tests++; if (frame_sum !== 32'd0) begin fails++; $display("FAIL reset_sum: got %0h want 0", frame_sum); end
        reset = 1'b0;
    endtask

    task automatic test_lock();
        int n;
        n_vs = 0;
        wait_lock();
        tests++; if (locked !== 1'b1) begin fails++; $display("FAIL lock_rise: locked %b want 1", locked); end
        tests++; if (n_vs !== 3) begin fails++; $display("FAIL lock_edge: locked at vsync edge %0d want 3", n_vs); end
        tests++; if (err_cnt !== 8'd0) begin fails++; $display("FAIL lock_err: got %0d want 0", err_cnt); end
        n = 0;
`ifdef FRAME_SUM_EN
        while (n_fsv == 0 && n < 2000) begin
            tick();
            n++;
        end
        tests++; if (fsv_sum !== 32'h000B_D000) begin fails++; $display("FAIL frame_sum: got %0h want bd000", fsv_sum); end
        tests++; if (fsv_vs !== 4) begin fails++; $display("FAIL frame_sum_edge: valid at vsync edge %0d want 4", fsv_vs); end
`else
        while (n < 1600) begin
            tick();
            n++;
        end
        tests++; if (n_fsv !== 0) begin fails++; $display("FAIL frame_sum_valid_off: %0d pulses want 0", n_fsv); end
        tests++; if (frame_sum !== 32'd0) begin fails++; $display("FAIL frame_sum_off: got %0h want 0", frame_sum); end
`endif
    endtask

    task automatic test_coords();
        goto(5, 3);
        tick();
        tests++; if (x !== 10'd5 || y !== 10'd3) begin fails++; $display("FAIL coord_xy: got (%0d,%0d) want (5,3)", x, y); end
        tests++; if (de !== 1'b1) begin fails++; $display("FAIL coord_de_active: got %b want 1", de); end
        @(posedge clk);
        #1;
        tests++; if (x !== 10'd5) begin fails++; $display("FAIL coord_hold: x %0d want 5 without p_tick", x); end
        goto(50, 3);
        tick();
        tests++; if (x !== 10'd50 || de !== 1'b0) begin fails++; $display("FAIL coord_hblank: x %0d de %b want 50 0", x, de); end
        goto(5, 20);
        tick();
        tests++; if (y !== 10'd20 || de !== 1'b0) begin fails++; $display("FAIL coord_vblank: y %0d de %b want 20 0", y, de); end
    endtask

    task automatic test_short_line();
        int base;
        goto(0, 5);
        htot = HT - 1;
        goto(0, 6);
        htot = HT;
        goto(HA + HFP, 6);
        tests++; if (locked !== 1'b1) begin fails++; $display("FAIL short_line_pre: locked %b want 1", locked); end
        tick();
        tests++; if (locked !== 1'b0) begin fails++; $display("FAIL short_line_unlock: locked %b want 0", locked); end
        tests++; if (err_cnt !== 8'd1) begin fails++; $display("FAIL short_line_err: got %0d want 1", err_cnt); end
        base = n_vs;
        wait_lock();
        tests++; if (locked !== 1'b1 || n_vs - base !== 3) begin
            fails++; $display("FAIL short_line_relock: locked %b after %0d edges want 1 after 3", locked, n_vs - base);
        end
    endtask

    task automatic test_short_frame();
        int base;
        goto(1, 0);
        vtot = VT - 1;
        goto(0, 0);
        vtot = VT;
        goto(0, VA + VFP);
        tests++; if (locked !== 1'b1) begin fails++; $display("FAIL short_frame_pre: locked %b want 1", locked); end
        tick();
        tests++; if (frame_start !== 1'b1) begin fails++; $display("FAIL frame_start_pulse: got %b want 1", frame_start); end
        tests++; if (locked !== 1'b0 || err_cnt !== 8'd2) begin
            fails++; $display("FAIL short_frame_err: locked %b err %0d want 0 2", locked, err_cnt);
        end
        @(posedge clk);
        #1;
        tests++; if (frame_start !== 1'b0) begin fails++; $display("FAIL frame_start_width: got %b want 0", frame_start); end
        base = n_vs;
        wait_lock();
        tests++; if (locked !== 1'b1 || n_vs - base !== 3) begin
            fails++; $display("FAIL short_frame_relock: locked %b after %0d edges want 1 after 3", locked, n_vs - base);
        end
    endtask

    task automatic test_timeout();
        goto(0, 0);
        tests++; if (locked !== 1'b1) begin fails++; $display("FAIL timeout_pre: locked %b want 1", locked); end
        hmask = 1;
        repeat (1100) tick();
        hmask = 0;
        tests++; if (locked !== 1'b0 || err_cnt !== 8'd3) begin
            fails++; $display("FAIL timeout_err: locked %b err %0d want 0 3", locked, err_cnt);
        end
        wait_lock();
        tests++; if (locked !== 1'b1 || err_cnt !== 8'd3) begin
            fails++; $display("FAIL timeout_relock: locked %b err %0d want 1 3", locked, err_cnt);
        end
    endtask

    task automatic test_mid_reset();
        goto(5, 3);
        tick();
        tests++; if (locked !== 1'b1) begin fails++; $display("FAIL mid_reset_pre: locked %b want 1", locked); end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        tests++; if (x !== 10'd0 || y !== 10'd0) begin fails++; $display("FAIL mid_reset_xy: got (%0d,%0d) want (0,0)", x, y); end
        tests++; if (locked !== 1'b0 || de !== 1'b0 || err_cnt !== 8'd0) begin
            fails++; $display("FAIL mid_reset_state: locked %b de %b err %0d want 0 0 0", locked, de, err_cnt);
        end
        tests++; if (frame_sum !== 32'd0) begin fails++; $display("FAIL mid_reset_sum: got %0h want 0", frame_sum); end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_coords();
        test_short_line();
        test_short_frame();
        test_timeout();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
